// File: rtl/esp_dma_mem_responder.sv
// rtl/esp_dma_mem_responder.sv - memory-side responder for the ESP accelerator DMA ctrl/chnl channels
// Single-port word RAM shared by a host port and a read/write DMA sequencer with a 2-entry read FIFO.
module esp_dma_mem_responder #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dma_read_ctrl_valid,
    output logic              dma_read_ctrl_ready,
    input  logic [31:0]       dma_read_ctrl_data_index,
    input  logic [31:0]       dma_read_ctrl_data_length,
    input  logic [2:0]        dma_read_ctrl_data_size,
    input  logic [5:0]        dma_read_ctrl_data_user,
    output logic              dma_read_chnl_valid,
    input  logic              dma_read_chnl_ready,
    output logic [DATA_W-1:0] dma_read_chnl_data,
    input  logic              dma_write_ctrl_valid,
    output logic              dma_write_ctrl_ready,
    input  logic [31:0]       dma_write_ctrl_data_index,
    input  logic [31:0]       dma_write_ctrl_data_length,
    input  logic [2:0]        dma_write_ctrl_data_size,
    input  logic [5:0]        dma_write_ctrl_data_user,
    input  logic              dma_write_chnl_valid,
    output logic              dma_write_chnl_ready,
    input  logic [DATA_W-1:0] dma_write_chnl_data,
    input  logic              host_en,
    input  logic              host_we,
    input  logic [AW-1:0]     host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    output logic              busy,
    output logic              addr_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} state_e;

    state_e              state_q, state_d;
    logic                ctrl_rdy_q;
    logic [AW-1:0]       idx_q;
    logic [31:0]         len_q;
    logic [8:0]          meta_q;
    logic [31:0]         issue_cnt_q;
    logic [31:0]         beat_cnt_q;
    logic                inflight_q;
    logic [DATA_W-1:0]   fifo_q [2];
    logic                fifo_wp_q;
    logic                fifo_rp_q;
    logic [1:0]          fifo_cnt_q;
    logic                addr_err_q;
    logic [DATA_W-1:0]   host_rdata_q;
    logic [DATA_W-1:0]   ram_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                rd_hs, wr_hs;
    logic [31:0]         req_idx, req_len;
    logic [8:0]          req_meta;
    logic [32:0]         req_end;
    logic                issue, push, pop, rd_beat, wr_beat, beat_last, host_rd;
    logic [1:0]          occ;
    logic [AW-1:0]       rd_addr, wr_addr, ram_addr;
    logic                ram_we;
    logic [DATA_W-1:0]   ram_wdata;
    logic                unused_meta;

    // Read wins a tie: the write side only sees ready when no read is requesting.
    assign dma_read_ctrl_ready  = ctrl_rdy_q;
    assign dma_write_ctrl_ready = ctrl_rdy_q && !dma_read_ctrl_valid;
    assign rd_hs = dma_read_ctrl_valid && dma_read_ctrl_ready;
    assign wr_hs = dma_write_ctrl_valid && dma_write_ctrl_ready;

    assign req_idx  = rd_hs ? dma_read_ctrl_data_index  : dma_write_ctrl_data_index;
    assign req_len  = rd_hs ? dma_read_ctrl_data_length : dma_write_ctrl_data_length;
    assign req_meta = rd_hs ? {dma_read_ctrl_data_size, dma_read_ctrl_data_user}
                            : {dma_write_ctrl_data_size, dma_write_ctrl_data_user};
    assign req_end  = {1'b0, req_idx} + {1'b0, req_len};
    assign unused_meta = ^meta_q;

    assign host_ack = host_en && ctrl_rdy_q && !rd_hs && !wr_hs;
    assign host_rd  = host_ack && !host_we;

    // Head of FIFO if anything is queued, otherwise the RAM output bypasses straight through.
    assign occ                 = fifo_cnt_q + {1'b0, inflight_q};
    assign issue               = (state_q == ST_RD) && (issue_cnt_q < len_q) && (occ < 2'd2);
    assign dma_read_chnl_valid = (state_q == ST_RD) && ((fifo_cnt_q != 2'd0) || inflight_q);
    assign dma_read_chnl_data  = (fifo_cnt_q != 2'd0) ? fifo_q[fifo_rp_q] : ram_q;
    assign rd_beat             = dma_read_chnl_valid && dma_read_chnl_ready;
    assign pop                 = (state_q == ST_RD) && (fifo_cnt_q != 2'd0) && dma_read_chnl_ready;
    assign push                = inflight_q && !((fifo_cnt_q == 2'd0) && dma_read_chnl_ready);

    assign dma_write_chnl_ready = (state_q == ST_WR) && (beat_cnt_q != len_q);
    assign wr_beat              = dma_write_chnl_valid && dma_write_chnl_ready;
    assign beat_last            = (beat_cnt_q + 32'd1) == len_q;

    assign rd_addr   = idx_q + issue_cnt_q[AW-1:0];
    assign wr_addr   = idx_q + beat_cnt_q[AW-1:0];
    assign ram_addr  = host_ack ? host_addr : ((state_q == ST_WR) ? wr_addr : rd_addr);
    assign ram_we    = (host_ack && host_we) || wr_beat;
    assign ram_wdata = host_ack ? host_wdata : dma_write_chnl_data;

    assign busy       = (state_q != ST_IDLE);
    assign addr_err   = addr_err_q;
    assign host_rdata = host_rdata_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_hs)      state_d = ST_RD;
                else if (wr_hs) state_d = ST_WR;
            end
            ST_RD: begin
                if (len_q == 32'd0 || (rd_beat && beat_last)) state_d = ST_IDLE;
            end
            ST_WR: begin
                if (len_q == 32'd0 || (wr_beat && beat_last)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ctrl_rdy_q   <= 1'b0;
            idx_q        <= '0;
            len_q        <= '0;
            meta_q       <= '0;
            issue_cnt_q  <= '0;
            beat_cnt_q   <= '0;
            inflight_q   <= 1'b0;
            fifo_wp_q    <= 1'b0;
            fifo_rp_q    <= 1'b0;
            fifo_cnt_q   <= '0;
            addr_err_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ctrl_rdy_q <= (state_d == ST_IDLE);
            inflight_q <= issue;
            if (rd_hs || wr_hs) begin
                idx_q       <= req_idx[AW-1:0];
                len_q       <= req_len;
                meta_q      <= req_meta;
                issue_cnt_q <= '0;
                beat_cnt_q  <= '0;
                if (req_end > 33'(DEPTH)) addr_err_q <= 1'b1;
            end else begin
                if (issue)              issue_cnt_q <= issue_cnt_q + 32'd1;
                if (rd_beat || wr_beat) beat_cnt_q  <= beat_cnt_q + 32'd1;
            end
            if (push) fifo_wp_q <= ~fifo_wp_q;
            if (pop)  fifo_rp_q <= ~fifo_rp_q;
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
            if (host_rd) host_rdata_q <= mem[ram_addr];
        end
    end

    // Storage and datapath registers carry no reset.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (issue)  ram_q <= mem[ram_addr];
        if (push)   fifo_q[fifo_wp_q] <= ram_q;
    end

endmodule
